bky_chain_shifter: RTL and testbench

BKY_CHAIN_SHIFTER -- requirements
Module: bky_chain_shifter

---
 rtl/bky_pkg.sv | 17 +
 rtl/bky_next_chip.sv | 25 ++
 rtl/bky_chain_shifter.sv | 162 ++++++++++++++++
 tb/tb_bky_chain_shifter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bky_pkg.sv
// rtl/bky_pkg.sv - shared state encoding and default sizing for the Buckeye chain shifter
package bky_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOW,
    HIGH,
    NEXT,
    FIN
  } state_t;

  localparam int DEF_NCHIP     = 6;
  localparam int DEF_CHIP_BITS = 48;
  localparam int DEF_CLK_DIV   = 2;

endpackage

// File: rtl/bky_next_chip.sv
// rtl/bky_next_chip.sv - finds the next selected chip above an index in a chip mask
module bky_next_chip #(
  parameter int NCHIP = 6,
  parameter int IDX_W = 3
) (
  input  logic [NCHIP-1:0] mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             first,
  output logic [IDX_W-1:0] nxt,
  output logic             found
);

  // Scan downward so the last hit is the lowest qualifying bit; 'first' searches from bit 0.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NCHIP - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bky_chain_shifter.sv
// rtl/bky_chain_shifter.sv - serial shifter writing/reading a chain of Buckeye chip shift registers
module bky_chain_shifter
  import bky_pkg::*;
#(
  parameter int NCHIP     = DEF_NCHIP,
  parameter int CHIP_BITS = DEF_CHIP_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [NCHIP-1:0] MASK,
  input  logic             DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             DOUT,
  output logic             DOUT_VALID,
  output logic [NCHIP-1:0] AMPIN,
  output logic [NCHIP-1:0] AMPCLK,
  input  logic [NCHIP-1:0] AMPOUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED
);

  localparam int CNT_W = $clog2(CHIP_BITS + 1);
  localparam int IDX_W = (NCHIP > 1) ? $clog2(NCHIP) : 1;
  localparam int DIV_W = 4;

  state_t           state;
  logic [NCHIP-1:0] mask_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] chip;
  logic [DIV_W-1:0] div_cnt;

  logic [NCHIP-1:0] search_mask;
  logic             search_first;
  logic [IDX_W-1:0] nxt_chip;
  logic             nxt_found;
  logic [NCHIP-1:0] chip_onehot;

  // In IDLE the search runs on the live MASK (lowest chip); afterwards on the latched mask above the active chip.
  assign search_mask  = (state == IDLE) ? MASK : mask_q;
  assign search_first = (state == IDLE);
  assign chip_onehot  = NCHIP'(1) << chip;

  bky_next_chip #(
    .NCHIP (NCHIP),
    .IDX_W (IDX_W)
  ) u_next_chip (
    .mask  (search_mask),
    .cur   (chip),
    .first (search_first),
    .nxt   (nxt_chip),
    .found (nxt_found)
  );

  // Sequencer: one bit per FETCH/LOW/HIGH/NEXT round, all outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mask_q     <= '0;
      bit_cnt    <= '0;
      chip       <= '0;
      div_cnt    <= '0;
      DIN_READY  <= 1'b0;
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
      AMPIN      <= '0;
      AMPCLK     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ABORTED    <= 1'b0;
    end else begin
      DONE       <= 1'b0;
      ABORTED    <= 1'b0;
      DOUT_VALID <= 1'b0;
      if (state != IDLE && ABORT) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        div_cnt   <= '0;
        DIN_READY <= 1'b0;
        DOUT      <= 1'b0;
        AMPIN     <= '0;
        AMPCLK    <= '0;
        BUSY      <= 1'b0;
        ABORTED   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              mask_q  <= MASK;
              BUSY    <= 1'b1;
              bit_cnt <= '0;
              div_cnt <= '0;
              if (nxt_found) begin
                chip      <= nxt_chip;
                DIN_READY <= 1'b1;
                state     <= FETCH;
              end else begin
                state <= FIN;
              end
            end
          end
          FETCH: begin
            if (DIN_VALID) begin
              DIN_READY <= 1'b0;
              AMPIN     <= DIN ? chip_onehot : '0;
              div_cnt   <= '0;
              state     <= LOW;
            end
          end
          LOW: begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
              div_cnt    <= '0;
              AMPCLK     <= chip_onehot;
              DOUT       <= AMPOUT[chip];
              DOUT_VALID <= 1'b1;
              state      <= HIGH;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          HIGH: begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
              div_cnt <= '0;
              AMPCLK  <= '0;
              state   <= NEXT;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          NEXT: begin
            AMPIN <= '0;
            if (bit_cnt == CNT_W'(CHIP_BITS - 1)) begin
              bit_cnt <= '0;
              if (nxt_found) begin
                chip      <= nxt_chip;
                DIN_READY <= 1'b1;
                state     <= FETCH;
              end else begin
                state <= FIN;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              DIN_READY <= 1'b1;
              state     <= FETCH;
            end
          end
          FIN: begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bky_chain_shifter.sv
// tb/tb_bky_chain_shifter.sv - self-checking bench with six modelled 48-bit chip shift registers
module tb_bky_chain_shifter;

  logic       CLK = 1'b0;
  logic       RST, START, ABORT, DIN, DIN_VALID;
  logic [5:0] MASK, AMPOUT;
  logic       DIN_READY, DOUT, DOUT_VALID, BUSY, DONE, ABORTED;
  logic [5:0] AMPIN, AMPCLK;

  bky_chain_shifter #(.NCHIP(6), .CHIP_BITS(48), .CLK_DIV(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MASK(MASK),
    .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .AMPIN(AMPIN), .AMPCLK(AMPCLK),
    .AMPOUT(AMPOUT), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [47:0] chip_reg [6];
  int          q_chip[$];
  bit          q_in[$];
  bit          q_dout[$];
  int          pulse_cnt [6];
  int          done_cnt = 0;
  int          abort_cnt = 0;
  int          dv_cnt = 0;
  logic [47:0] dout_acc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // External chips: each presents its LSB and shifts AMPIN in at the MSB on every AMPCLK rise.
  always_comb for (int i = 0; i < 6; i++) AMPOUT[i] = chip_reg[i][0];

  initial begin : monitor
    logic [5:0] prev_clk, prev_in, allowed;
    int last_chip;
    last_chip = -1;
    prev_clk  = '0;
    prev_in   = '0;
    for (int i = 0; i < 6; i++) begin
      chip_reg[i]  = {8'(8'hC0 + i), 40'h123456789A};
      pulse_cnt[i] = 0;
    end
    forever begin
      @(negedge CLK);
      if (DONE) done_cnt++;
      if (ABORTED) abort_cnt++;
      if (!RST) begin
        allowed = '0;
        if (q_chip.size() > 0) allowed[q_chip[0]] = 1'b1;
        if (last_chip >= 0) allowed[last_chip] = 1'b1;
        chk("ampclk_inactive", AMPCLK & ~allowed, 0);
        chk("ampin_inactive", AMPIN & ~allowed, 0);
        for (int i = 0; i < 6; i++) begin
          if (prev_clk[i] && AMPCLK[i]) chk("ampin_stable_high", AMPIN[i], prev_in[i]);
          if (AMPCLK[i] && !prev_clk[i]) begin
            pulse_cnt[i]++;
            last_chip = i;
            if (q_chip.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_pulse: got pulse on chip %0d expected none", i);
            end else begin
              chk("pulse_chip", i, q_chip.pop_front());
              chk("pulse_ampin", AMPIN[i], q_in.pop_front());
            end
            chip_reg[i] = {AMPIN[i], chip_reg[i][47:1]};
          end
        end
        if (DOUT_VALID) begin
          dv_cnt++;
          dout_acc = {DOUT, dout_acc[47:1]};
          if (q_dout.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_dout: got DOUT_VALID expected none");
          end else begin
            chk("dout", DOUT, q_dout.pop_front());
          end
        end
      end
      prev_clk = AMPCLK;
      prev_in  = AMPIN;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one sequence; kill_at>0 aborts (or resets) right after that many bits were accepted.
  task automatic run_seq(input logic [5:0] m, input logic [287:0] s, input int stall_after,
                         input int stall_len, input int kill_at, input bit kill_rst,
                         input bit with_abort, input string tag);
    logic [47:0] exp_final [6];
    int pc0 [6];
    int n, k, nbits, budget, d0, a0, tot;
    bit acc;
    n = 0; k = 0; d0 = done_cnt; a0 = abort_cnt;
    for (int i = 0; i < 6; i++) begin
      pc0[i] = pulse_cnt[i];
      exp_final[i] = chip_reg[i];
      if (m[i]) begin
        exp_final[i] = s[n*48 +: 48];
        for (int b = 0; b < 48; b++) begin
          q_chip.push_back(i);
          q_in.push_back(s[n*48 + b]);
          q_dout.push_back(chip_reg[i][b]);
        end
        n++;
      end
    end
    nbits = n * 48;
    START = 1'b1; MASK = m; ABORT = with_abort;
    tick();
    START = 1'b0; ABORT = 1'b0; MASK = ~m;
    chk({tag, "_busy_after_start"}, BUSY, 1);
    chk({tag, "_no_aborted"}, ABORTED, 0);
    DIN = s[0]; DIN_VALID = 1'b1; budget = 0;
    while (k < nbits && budget < 20000) begin
      @(negedge CLK);
      acc = DIN_READY && DIN_VALID;
      tick();
      budget++;
      if (acc) begin
        k++;
        if (k == kill_at) begin
          DIN_VALID = 1'b0;
          if (kill_rst) RST = 1'b1; else ABORT = 1'b1;
          tick();
          ABORT = 1'b0;
          chk({tag, "_kill_ampclk"}, AMPCLK, 0);
          chk({tag, "_kill_ampin"}, AMPIN, 0);
          chk({tag, "_kill_busy"}, BUSY, 0);
          chk({tag, "_kill_done"}, DONE, 0);
          chk({tag, "_kill_din_ready"}, DIN_READY, 0);
          chk({tag, "_kill_dout_valid"}, DOUT_VALID, 0);
          chk({tag, "_kill_aborted"}, ABORTED, !kill_rst);
          if (kill_rst) begin
            chk({tag, "_kill_dout"}, DOUT, 0);
            START = 1'b1;
            tick();
            START = 1'b0;
            tick();
            RST = 1'b0;
            repeat (3) tick();
            chk({tag, "_start_in_reset_ignored"}, BUSY, 0);
          end else begin
            tick();
            chk({tag, "_aborted_one_cycle"}, ABORTED, 0);
          end
          q_chip.delete(); q_in.delete(); q_dout.delete();
          tot = 0;
          for (int i = 0; i < 6; i++) tot += pulse_cnt[i] - pc0[i];
          chk({tag, "_pulses_before_kill"}, tot, kill_at - 1);
          chk({tag, "_kill_no_done"}, done_cnt - d0, 0);
          chk({tag, "_aborted_count"}, abort_cnt - a0, !kill_rst);
          return;
        end
        if (k == stall_after) begin
          DIN_VALID = 1'b0;
          repeat (stall_len) tick();
          chk({tag, "_stall_ampclk_low"}, AMPCLK, 0);
          chk({tag, "_stall_din_ready"}, DIN_READY, 1);
          tot = 0;
          for (int i = 0; i < 6; i++) tot += pulse_cnt[i] - pc0[i];
          chk({tag, "_stall_pulse_count"}, tot, k);
          DIN_VALID = 1'b1;
        end
        if (k < nbits) DIN = s[k];
      end
    end
    DIN_VALID = 1'b0;
    chk({tag, "_bits_accepted"}, k, nbits);
    budget = 0;
    while (done_cnt == d0 && budget < 2000) begin
      @(negedge CLK);
      budget++;
    end
    repeat (3) @(negedge CLK);
    chk({tag, "_one_done"}, done_cnt - d0, 1);
    chk({tag, "_busy_after_done"}, BUSY, 0);
    chk({tag, "_pulses_left"}, q_chip.size(), 0);
    chk({tag, "_dout_left"}, q_dout.size(), 0);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_chip_contents"}, chip_reg[i], exp_final[i]);
      chk({tag, "_chip_pulses"}, pulse_cnt[i] - pc0[i], m[i] ? 48 : 0);
    end
    tick();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    int d0, dv0, p0;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; MASK = '0; DIN = 1'b0; DIN_VALID = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {DIN_READY, DOUT, DOUT_VALID, AMPIN, AMPCLK, BUSY, DONE, ABORTED}, 0);
    RST = 1'b0;
    tick();

    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("idle_abort_ignored", ABORTED, 0);
    chk("idle_abort_busy", BUSY, 0);

    run_seq(6'b001000, {240'h0, 48'h3F78D2BC9AE1}, -1, 0, -1, 1'b0, 1'b0, "single");
    chk("single_chip4_literal", chip_reg[3], 48'h3F78D2BC9AE1);
    chk("single_dout_literal", dout_acc, 48'hC3123456789A);

    run_seq(6'b111111, {48'h111111111111, 48'h222222222222, 48'h333333333333,
                        48'h444444444444, 48'h555555555555, 48'h666666666666},
            -1, 0, -1, 1'b0, 1'b0, "all");
    chk("all_chip1_literal", chip_reg[0], 48'h666666666666);
    chk("all_chip6_literal", chip_reg[5], 48'h111111111111);

    d0 = done_cnt; dv0 = dv_cnt; p0 = 0;
    for (int i = 0; i < 6; i++) p0 += pulse_cnt[i];
    START = 1'b1; MASK = '0;
    tick();
    START = 1'b0;
    chk("mask0_busy_cycle1", BUSY, 1);
    chk("mask0_done_cycle1", DONE, 0);
    tick();
    chk("mask0_done_cycle2", DONE, 1);
    chk("mask0_busy_cycle2", BUSY, 0);
    tick();
    chk("mask0_done_cycle3", DONE, 0);
    for (int i = 0; i < 6; i++) p0 -= pulse_cnt[i];
    chk("mask0_no_pulses", p0, 0);
    chk("mask0_no_dout", dv_cnt - dv0, 0);
    chk("mask0_done_count", done_cnt - d0, 1);

    run_seq(6'b010000, {240'h0, 48'h84210FEDCBA9}, 21, 12, -1, 1'b0, 1'b1, "stall");

    run_seq(6'b000110, {96'h0, 48'h0123456789AB, 48'hBA9876543210, 48'hFEDCBA987654},
            -1, 0, 54, 1'b0, 1'b0, "abort");
    run_seq(6'b000110, {192'h0, 48'hCAFEF00D1234, 48'h5A5A3C3C9696}, -1, 0, -1, 1'b0, 1'b0,
            "after_abort");

    run_seq(6'b111111, {48'hAAAA55550000, 48'h0F0F0F0F0F0F, 48'h123123123123,
                        48'h777777777777, 48'h89ABCDEF0123, 48'h456456456456},
            -1, 0, 100, 1'b1, 1'b0, "reset");
    run_seq(6'b101001, {144'h0, 48'hDEADBEEF0123, 48'h0F1E2D3C4B5A, 48'h13579BDF2468},
            -1, 0, -1, 1'b0, 1'b0, "after_reset");
    chk("after_reset_chip1_literal", chip_reg[0], 48'h13579BDF2468);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
